// File: rtl/hdmi_video_pkg.sv
// Shared timing constants and enumerations for the HDMI pattern path.
package hdmi_video_pkg;

    // 640x480@60 raster timing
    localparam int unsigned VGA_HA  = 640;
    localparam int unsigned VGA_HFP = 16;
    localparam int unsigned VGA_HSW = 96;
    localparam int unsigned VGA_HBP = 48;
    localparam int unsigned VGA_VA  = 480;
    localparam int unsigned VGA_VFP = 10;
    localparam int unsigned VGA_VSW = 2;
    localparam int unsigned VGA_VBP = 33;

    typedef enum logic [1:0] {
        PAT_SMPTE,
        PAT_RAMP,
        PAT_CHECKER,
        PAT_SOLID
    } pattern_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } vtc_state_e;

    // Total length of one raster axis (active + front porch + sync + back porch)
    function automatic int unsigned axis_total(
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sw,
        input int unsigned bp
    );
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus look-ahead decodes.
// active/sync describe the value the counter takes at the coming edge, so the
// parent can register them in step with the counter itself.
module video_axis_counter #(
    parameter int unsigned MAX = 800,
    parameter int unsigned ACT = 640,
    parameter int unsigned FP  = 16,
    parameter int unsigned SW  = 96,
    localparam int unsigned W  = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic [31:0]  next_wide;

    assign wrap  = (count_reg == W'(MAX - 1));
    assign count = count_reg;

    // Next position: clear wins over increment; increment wraps at MAX-1
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            count_next = wrap ? '0 : count_reg + W'(1);
        end
        next_wide = 32'(count_next);
        active    = (next_wide < ACT);
        sync      = (next_wide >= ACT + FP) && (next_wide < ACT + FP + SW);
    end

    // Position register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_controller.sv
// Frame sequencer: raster counters, sync/DE decode, line/frame strobes and a
// frame-aligned pattern-mode handshake. Starts and stops on frame boundaries.
module video_timing_controller
    import hdmi_video_pkg::*;
#(
    parameter int unsigned HA        = VGA_HA,
    parameter int unsigned HFP       = VGA_HFP,
    parameter int unsigned HSW       = VGA_HSW,
    parameter int unsigned HBP       = VGA_HBP,
    parameter int unsigned VA        = VGA_VA,
    parameter int unsigned VFP       = VGA_VFP,
    parameter int unsigned VSW       = VGA_VSW,
    parameter int unsigned VBP       = VGA_VBP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned MODE_W    = 2,
    localparam int unsigned HMAX     = axis_total(HA, HFP, HSW, HBP),
    localparam int unsigned VMAX     = axis_total(VA, VFP, VSW, VBP),
    localparam int unsigned HW       = $clog2(HMAX),
    localparam int unsigned VW       = $clog2(VMAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_mode_valid,
    output logic              o_mode_ready,
    output logic [MODE_W-1:0] o_mode,
    output logic [HW-1:0]     o_hcount,
    output logic [VW-1:0]     o_vcount,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic              o_line_start,
    output logic              o_frame_start,
    output logic              o_running
);

    vtc_state_e state_reg, state_next;

    logic h_inc, h_clr, v_inc, v_clr;
    logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

    logic running_next, line_start_next, frame_start_next, xfer;

    logic              hsync_reg, vsync_reg, de_reg;
    logic              line_start_reg, frame_start_reg, running_reg;
    logic [MODE_W-1:0] mode_reg, pend_mode_reg;
    logic              pend_valid_reg, ready_reg;

    video_axis_counter #(
        .MAX(HMAX), .ACT(HA), .FP(HFP), .SW(HSW)
    ) u_haxis (
        .clk(clk), .rst(rst), .inc(h_inc), .clr(h_clr),
        .count(o_hcount), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    video_axis_counter #(
        .MAX(VMAX), .ACT(VA), .FP(VFP), .SW(VSW)
    ) u_vaxis (
        .clk(clk), .rst(rst), .inc(v_inc), .clr(v_clr),
        .count(o_vcount), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    // Next state, counter control and look-ahead strobes for the next cycle
    always_comb begin
        state_next = state_reg;
        h_inc      = 1'b0;
        h_clr      = 1'b0;
        case (state_reg)
            IDLE: begin
                h_clr = 1'b1;
                if (i_en) state_next = RUN;
            end
            RUN: begin
                h_inc = 1'b1;
                if (!i_en) state_next = DRAIN;
            end
            DRAIN: begin
                h_inc = 1'b1;
                if (i_en) begin
                    state_next = RUN;
                end else if (h_wrap && v_wrap) begin
                    // last pixel of the frame: stop cleanly on the boundary
                    state_next = IDLE;
                    h_clr      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                h_clr      = 1'b1;
            end
        endcase
        v_inc = h_inc && h_wrap;
        v_clr = h_clr;

        running_next     = (state_next != IDLE);
        // leaving IDLE always lands on (0,0); otherwise zero follows a wrap
        line_start_next  = running_next && ((state_reg == IDLE) || h_wrap);
        frame_start_next = running_next && ((state_reg == IDLE) || (h_wrap && v_wrap));
        xfer             = i_mode_valid && ready_reg;
    end

    // State, decoded outputs and the mode handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            hsync_reg       <= ~HSYNC_POL;
            vsync_reg       <= ~VSYNC_POL;
            de_reg          <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            running_reg     <= 1'b0;
            mode_reg        <= '0;
            pend_mode_reg   <= '0;
            pend_valid_reg  <= 1'b0;
            ready_reg       <= 1'b1;
        end else begin
            state_reg       <= state_next;
            hsync_reg       <= (running_next && h_sync) ? HSYNC_POL : ~HSYNC_POL;
            vsync_reg       <= (running_next && v_sync) ? VSYNC_POL : ~VSYNC_POL;
            de_reg          <= running_next && h_act && v_act;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            running_reg     <= running_next;

            // only a request already pending before this edge is applied, so
            // a transfer coinciding with the frame wrap waits one more frame
            if (frame_start_next && pend_valid_reg) begin
                mode_reg <= pend_mode_reg;
            end
            if (xfer) begin
                pend_valid_reg <= 1'b1;
                pend_mode_reg  <= i_mode;
            end else if (frame_start_next) begin
                pend_valid_reg <= 1'b0;
            end
            // ready reopens the cycle after the pending value is consumed
            ready_reg <= !pend_valid_reg && !xfer;
        end
    end

    assign o_hsync       = hsync_reg;
    assign o_vsync       = vsync_reg;
    assign o_de          = de_reg;
    assign o_line_start  = line_start_reg;
    assign o_frame_start = frame_start_reg;
    assign o_running     = running_reg;
    assign o_mode        = mode_reg;
    assign o_mode_ready  = ready_reg;

endmodule

// File: tb/tb_video_timing_controller.sv
// Bench for video_timing_controller on a reduced 16x8 raster.
// The reference model tracks a frame pixel index and derives every output from it.
module tb_video_timing_controller;

    localparam int T_HA = 8, T_HFP = 2, T_HSW = 3, T_HBP = 3;
    localparam int T_VA = 4, T_VFP = 1, T_VSW = 2, T_VBP = 1;
    localparam int T_HMAX  = T_HA + T_HFP + T_HSW + T_HBP;
    localparam int T_VMAX  = T_VA + T_VFP + T_VSW + T_VBP;
    localparam int T_FRAME = T_HMAX * T_VMAX;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_en = 1'b0;
    logic       i_mode_valid = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic       o_mode_ready;
    logic [1:0] o_mode;
    logic [3:0] o_hcount;
    logic [2:0] o_vcount;
    logic       o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_running;

    video_timing_controller #(
        .HA(T_HA), .HFP(T_HFP), .HSW(T_HSW), .HBP(T_HBP),
        .VA(T_VA), .VFP(T_VFP), .VSW(T_VSW), .VBP(T_VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .MODE_W(2)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode),
        .i_mode_valid(i_mode_valid), .o_mode_ready(o_mode_ready),
        .o_mode(o_mode), .o_hcount(o_hcount), .o_vcount(o_vcount),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_running(o_running)
    );

    always #5 clk = ~clk;

    // reference model state
    bit       m_run = 0, m_drain = 0, m_fs = 0, m_ls = 0, m_pend = 0, m_ready = 1;
    int       m_p = 0;
    bit [1:0] m_mode = 0, m_pend_mode = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic logic [15:0] exp_vec();
        int h, v;
        bit hs_on, vs_on, de;
        h     = m_run ? m_p % T_HMAX : 0;
        v     = m_run ? m_p / T_HMAX : 0;
        de    = m_run && (h < T_HA) && (v < T_VA);
        hs_on = m_run && (h >= T_HA + T_HFP) && (h < T_HA + T_HFP + T_HSW);
        vs_on = m_run && (v >= T_VA + T_VFP) && (v < T_VA + T_VFP + T_VSW);
        return {4'(h), 3'(v), ~hs_on, ~vs_on, de, m_ls, m_fs, m_run, m_mode, m_ready};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {o_hcount, o_vcount, o_hsync, o_vsync, o_de, o_line_start,
                o_frame_start, o_running, o_mode, o_mode_ready};
    endfunction

    // advance the model by one clock edge using the inputs about to be sampled
    task automatic model_update();
        bit had_pend, xfer;
        if (rst) begin
            m_run = 0; m_drain = 0; m_p = 0; m_fs = 0; m_ls = 0;
            m_mode = 0; m_pend = 0; m_ready = 1;
            return;
        end
        xfer = i_mode_valid && m_ready;
        if (!m_run) begin
            if (i_en) begin
                m_run = 1; m_p = 0; m_drain = 0;
            end
        end else if (m_drain && !i_en && m_p == T_FRAME - 1) begin
            m_run = 0; m_p = 0; m_drain = 0;
        end else begin
            m_p     = (m_p + 1) % T_FRAME;
            m_drain = !i_en;
        end
        m_fs = m_run && (m_p == 0);
        m_ls = m_run && (m_p % T_HMAX == 0);
        had_pend = m_pend;
        if (m_fs && m_pend) begin
            m_mode = m_pend_mode;
            m_pend = 0;
        end
        if (xfer) begin
            m_pend      = 1;
            m_pend_mode = i_mode;
            $display("mode transfer: mode=%0d at cyc=%0d", i_mode, cyc);
        end
        m_ready = !had_pend && !xfer;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    // advance (checking every cycle) until the model shows frame index target
    task automatic run_to(input int target, input string tag);
        for (int i = 0; i < 2 * T_FRAME && !(m_run && m_p == target); i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic wait_fs(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * T_FRAME && !found; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, dut_vec(), exp_vec());
            end
            if (o_frame_start === 1'b1) found = 1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout waiting for frame_start", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_en = 1'b0; i_mode_valid = 1'b0;
        run_cycles(2, "reset");
        n_checks++;
        if ({o_hcount, o_vcount, o_hsync, o_vsync, o_de, o_running, o_mode_ready} !== 12'b0000_000_11_0_0_1) begin
            n_fail++;
            $display("FAIL reset_values got h=%0d v=%0d hs=%b vs=%b de=%b run=%b rdy=%b",
                     o_hcount, o_vcount, o_hsync, o_vsync, o_de, o_running, o_mode_ready);
        end
        rst = 1'b0;
        run_cycles(3, "idle_hold");
    endtask

    task automatic test_start();
        int fs_cnt, vs_low, hs_low, de_cnt;
        fs_cnt = 0; vs_low = 0; hs_low = 0; de_cnt = 0;
        i_en = 1'b1;
        run_cycles(1, "start");
        n_checks++;
        if ({o_frame_start, o_line_start, o_de, o_running} !== 4'b1111) begin
            n_fail++;
            $display("FAIL start_latency got fs=%b ls=%b de=%b run=%b expected all 1",
                     o_frame_start, o_line_start, o_de, o_running);
        end
        for (int i = 0; i < 2 * T_FRAME; i++) begin
            if (i > 0) run_cycles(1, "two_frames");
            fs_cnt += int'(o_frame_start);
            vs_low += int'(!o_vsync);
            hs_low += int'(!o_hsync);
            de_cnt += int'(o_de);
        end
        n_checks++;
        if (fs_cnt != 2 || vs_low != 64 || hs_low != 48 || de_cnt != 64) begin
            n_fail++;
            $display("FAIL frame_counts got fs=%0d vs_low=%0d hs_low=%0d de=%0d expected 2/64/48/64",
                     fs_cnt, vs_low, hs_low, de_cnt);
        end
    endtask

    task automatic test_drain();
        int n, start_cyc;
        run_to(2 * T_HMAX + 3, "drain_pos");
        i_en = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * T_FRAME && o_running === 1'b1; i++) begin
            run_cycles(1, "drain");
            n++;
        end
        n_checks++;
        if (n != T_FRAME - (2 * T_HMAX + 3) || o_running !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_len got %0d cycles run=%b expected %0d cycles run=0",
                     n, o_running, T_FRAME - (2 * T_HMAX + 3));
        end
        i_en = 1'b1;
        run_cycles(1, "restart");
        start_cyc = cyc;
        n_checks++;
        if (o_frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_fs got %b expected 1", o_frame_start);
        end
        run_to(50, "rejoin_pos");
        i_en = 1'b0;
        run_cycles(10, "drain_short");
        i_en = 1'b1;
        wait_fs("rejoin");
        n_checks++;
        if (cyc - start_cyc != T_FRAME) begin
            n_fail++;
            $display("FAIL drain_rejoin spacing got %0d expected %0d", cyc - start_cyc, T_FRAME);
        end
    endtask

    task automatic test_mode();
        int  fs_seen;
        bit  accepted;
        run_to(20, "mode_pos");
        i_mode = 2'd2; i_mode_valid = 1'b1;
        run_cycles(1, "mode_req");
        n_checks++;
        if (o_mode_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop got %b expected 0", o_mode_ready);
        end
        i_mode = 2'd3;
        fs_seen = 0;
        for (int i = 0; i < 3 * T_FRAME && fs_seen < 2; i++) begin
            accepted = i_mode_valid && o_mode_ready;
            run_cycles(1, "mode_stall");
            if (accepted) begin
                i_mode_valid = 1'b0;
                n_checks++;
                if (fs_seen == 0) begin
                    n_fail++;
                    $display("FAIL mode_stall second request accepted before first applied");
                end
            end
            if (o_frame_start === 1'b1) begin
                fs_seen++;
                n_checks++;
                if (o_mode !== (fs_seen == 1 ? 2'd2 : 2'd3)) begin
                    n_fail++;
                    $display("FAIL mode_apply frame %0d got %0d expected %0d",
                             fs_seen, o_mode, fs_seen == 1 ? 2 : 3);
                end
            end
        end
        n_checks++;
        if (fs_seen != 2) begin
            n_fail++;
            $display("FAIL mode_frames got %0d frame starts expected 2", fs_seen);
        end
    endtask

    task automatic test_wrap_mode();
        run_to(T_FRAME - 1, "wrap_pos");
        i_mode = 2'd1; i_mode_valid = 1'b1;
        run_cycles(1, "wrap_req");
        i_mode_valid = 1'b0;
        n_checks++;
        if (o_frame_start !== 1'b1 || o_mode !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_immediate got fs=%b mode=%0d expected fs=1 mode=3", o_frame_start, o_mode);
        end
        wait_fs("wrap_next_fs");
        n_checks++;
        if (o_mode !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_next got mode=%0d expected 1", o_mode);
        end
    endtask

    task automatic test_rst_mid();
        run_to(3 * T_HMAX + 5, "rst_pos");
        i_mode = 2'd2; i_mode_valid = 1'b1;
        run_cycles(1, "rst_req");
        i_mode_valid = 1'b0;
        rst = 1'b1;
        run_cycles(1, "rst_mid");
        n_checks++;
        if ({o_hcount, o_vcount, o_running, o_mode, o_mode_ready, o_de} !== 12'b0000_000_0_00_1_0) begin
            n_fail++;
            $display("FAIL rst_values got h=%0d v=%0d run=%b mode=%0d rdy=%b de=%b",
                     o_hcount, o_vcount, o_running, o_mode, o_mode_ready, o_de);
        end
        rst = 1'b0; i_en = 1'b1;
        run_cycles(1, "rst_restart");
        n_checks++;
        if (o_frame_start !== 1'b1 || o_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_no_stale got fs=%b mode=%0d expected fs=1 mode=0", o_frame_start, o_mode);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) i_en = ~i_en;
            i_mode_valid = ($urandom_range(0, 7) == 0);
            i_mode       = 2'($urandom_range(0, 3));
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h expected=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_drain();
        test_mode();
        test_wrap_mode();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timing_controller.md
Name: video_timing_controller

Overview:
- Frame sequencer for the HDMI pattern path.
- Generates raster counters, sync, data-enable and frame/line strobes that drive the test pattern generator and the TMDS encoders.
- Starts and stops only on frame boundaries.
- Accepts pattern-mode change requests through a valid/ready handshake and applies each accepted mode at the next frame start, so a frame never mixes modes.

Parameters:
- HA, 640, active pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSW, 96, hsync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VA, 480, active lines
- VFP, 10, vertical front porch (lines)
- VSW, 2, vsync width (lines)
- VBP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level
- VSYNC_POL, 0, vsync active level
- MODE_W, 2, pattern-mode select width
- Derived localparams: HMAX = HA+HFP+HSW+HBP; VMAX = VA+VFP+VSW+VBP; HW = $clog2(HMAX); VW = $clog2(VMAX).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- i_en  in  1  run request; level-sensitive
- i_mode  in  MODE_W  requested pattern mode
- i_mode_valid  in  1  mode request valid
- o_mode_ready  out  1  controller can accept a mode request
- o_mode  out  MODE_W  mode in force for the current frame
- o_hcount  out  HW  horizontal position
- o_vcount  out  VW  vertical position
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  active-video enable
- o_line_start  out  1  pulse when o_hcount==0 while running
- o_frame_start  out  1  pulse when o_hcount==0 and o_vcount==0 while running
- o_running  out  1  high in RUN or DRAIN

Behaviour:
- Interface timing:
  - One clock domain (clk). Reset is synchronous and active-high (rst).
  - All outputs are registered.
  - In any cycle, o_hsync, o_vsync, o_de and the strobes describe the o_hcount/o_vcount pair shown in that same cycle.
- Reset values:
  - State IDLE.
  - o_hcount = 0, o_vcount = 0.
  - o_hsync = ~HSYNC_POL, o_vsync = ~VSYNC_POL.
  - o_de, o_line_start, o_frame_start, o_running = 0.
  - o_mode = 0, pending mode cleared, o_mode_ready = 1.
- Decode (RUN/DRAIN only):
  - o_de = (h < HA) && (v < VA).
  - hsync is active when HA+HFP <= h < HA+HFP+HSW.
  - vsync is active when VA+VFP <= v < VA+VFP+VSW, for whole lines.
- Counters:
  - h increments every cycle and wraps HMAX-1 -> 0.
  - v increments when h wraps and wraps VMAX-1 -> 0.
- IDLE:
  - Counters held at 0; syncs inactive; de = 0.
  - If i_en is sampled high, the next cycle is RUN with h = 0, v = 0, o_frame_start = 1 and o_line_start = 1. Start latency is 1 cycle.
- RUN:
  - Free-running raster.
  - i_en sampled low -> DRAIN.
- DRAIN:
  - Continues the raster.
  - i_en sampled high -> RUN, with no discontinuity.
  - At the edge where h = HMAX-1 and v = VMAX-1 with i_en low -> IDLE. The next cycle shows counters 0 and o_running = 0.
  - A partial frame is never emitted.
- Mode handshake:
  - A transfer occurs when i_mode_valid && o_mode_ready.
  - A transfer loads the pending register and drops ready.
  - Each cycle with o_frame_start = 1 shows o_mode = the pending value, if a pending value existed before that edge. Pending then clears and ready returns high the following cycle.
  - A transfer at the same edge as the frame wrap is applied at the following frame.
  - The first frame after IDLE also applies a pending mode.
  - While pending is set, further requests stall (ready = 0) and are not dropped.
- rst mid-frame: immediate return to reset values on the next edge; any pending request is discarded.

Decomposition:
- hdmi_video_pkg holds:
  - 640x480@60 timing constants (HA/HFP/HSW/HBP, VA/VFP/VSW/VBP);
  - typedef enum pattern_mode_e {PAT_SMPTE, PAT_RAMP, PAT_CHECKER, PAT_SOLID};
  - typedef enum vtc_state_e {IDLE, RUN, DRAIN}.
- One sub-module, video_axis_counter:
  - parameters MAX, ACT, FP, SW;
  - inputs inc, clr;
  - outputs count, wrap, active, sync.
  - Instantiated once for the horizontal axis and once for the vertical axis.

Test Plan (reduced timing: HA=8 HFP=2 HSW=3 HBP=3 → HMAX=16; VA=4 VFP=1 VSW=2 VBP=1 → VMAX=8):
- Reset, then i_en=1 at cycle 0 -> cycle 1: h=0, v=0, frame_start=1, de=1. h=10..12 hsync low; h=8 de=0; h=15→0 with v=1 and line_start=1.
- Run two frames -> vsync low exactly for v=5,6, i.e. 32 cycles per frame. Frame_start every 128 cycles. de high for 32 cycles per frame.
- Drop i_en at h=3, v=2 -> raster continues to h=15, v=7, then o_running=0 and counters 0. Re-assert i_en during DRAIN -> no gap, next frame_start at a 128-cycle spacing.
- Send mode=2 mid-frame -> ready low next cycle. A second request (mode=3) is held off. o_mode=2 at the next frame_start. Mode=3 is accepted afterwards and applied one frame later.
- Send mode=1 on the cycle where h=15, v=7 -> o_mode unchanged at the immediate frame_start; becomes 1 at the following frame_start.
- Assert rst at h=6, v=3 with a request pending -> next cycle shows all reset values and ready=1. After release with i_en high, frame_start occurs with o_mode=0.
